prefix_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone prefix adder. Next generation of the team's 6-bit combinational prefix adder: arbitrary WIDTH, configurable pipeline depth, valid/ready handshake with per-stage bubble collapsing. Sits on datapath buses where the combinational adder cannot meet timing at wide widths.

---
 rtl/prefix_adder_pkg.sv | 20 ++
 rtl/pg_cell.sv | 12 +
 rtl/prefix_adder_pipe.sv | 145 ++++++++++++++
 tb/tb_prefix_adder_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone prefix adder.
package prefix_adder_pkg;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int level_span(input int l);
        return 1 << l;
    endfunction

endpackage

// File: rtl/pg_cell.sv
// Kogge-Stone black cell: merges a high group with the adjacent low group.
module pg_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic G,
    output logic P
);
    assign G = g_hi | (p_hi & g_lo);
    assign P = p_hi & p_lo;
endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready stages and bubble collapsing.
// Optional ADDSUB_EN macro adds a `sub` port for X - Y.
module prefix_adder_pipe
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int LVL_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             c_in,
`ifdef ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   S
);
    localparam int LEVELS = clog2(WIDTH);
    localparam int K      = (LEVELS + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

    logic [K:0]            v_q, v_d, ci_q, ci_d;
    logic [K:0][WIDTH-1:0] praw_q, praw_d, gg_q, gg_d, pp_q, pp_d;
    logic [K:1][WIDTH-1:0] cg, cp;
    logic [K:0]            rdy;

    pg_t  [WIDTH-1:0] pre;
    logic [WIDTH-1:0] pre_p, pre_g, y_eff;
    logic             ci_eff;

    always_comb begin
        y_eff  = Y;
        ci_eff = c_in;
`ifdef ADDSUB_EN
        if (sub) begin
            y_eff  = ~Y;
            ci_eff = 1'b1;
        end
`endif
        for (int i = 0; i < WIDTH; i++) begin
            pre[i].p = X[i] ^ y_eff[i];
            pre[i].g = X[i] & y_eff[i];
        end
        // carry-in folded into bit 0 so the prefix tree needs no extra column
        pre[0].g = pre[0].g | (pre[0].p & ci_eff);
        for (int i = 0; i < WIDTH; i++) begin
            pre_p[i] = pre[i].p;
            pre_g[i] = pre[i].g;
        end
    end

    for (genvar n = 1; n <= K; n++) begin : g_stage
        for (genvar j = 0; j < LVL_PER_STAGE; j++) begin : g_lvl
            localparam int L = (n - 1) * LVL_PER_STAGE + j;
            logic [WIDTH-1:0] g_in, p_in, g_out, p_out;
            if (j == 0) begin : g_first
                assign g_in = gg_q[n-1];
                assign p_in = pp_q[n-1];
            end else begin : g_chain
                assign g_in = g_lvl[j-1].g_out;
                assign p_in = g_lvl[j-1].p_out;
            end
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (L < LEVELS && i >= level_span(L)) begin : g_cell
                    pg_cell u_cell (
                        .g_hi(g_in[i]),
                        .p_hi(p_in[i]),
                        .g_lo(g_in[i-level_span(L)]),
                        .p_lo(p_in[i-level_span(L)]),
                        .G   (g_out[i]),
                        .P   (p_out[i])
                    );
                end else begin : g_pass
                    assign g_out[i] = g_in[i];
                    assign p_out[i] = p_in[i];
                end
            end
        end
        assign cg[n] = g_lvl[LVL_PER_STAGE-1].g_out;
        assign cp[n] = g_lvl[LVL_PER_STAGE-1].p_out;
    end

    // a stage may load if empty or if its occupant moves on this cycle
    always_comb begin
        logic acc;
        acc = out_ready;
        for (int n = K; n >= 0; n--) begin
            acc    = !v_q[n] || acc;
            rdy[n] = acc;
        end
    end

    always_comb begin
        v_d    = v_q;
        ci_d   = ci_q;
        praw_d = praw_q;
        gg_d   = gg_q;
        pp_d   = pp_q;
        if (rdy[0]) begin
            v_d[0]    = in_valid;
            ci_d[0]   = ci_eff;
            praw_d[0] = pre_p;
            gg_d[0]   = pre_g;
            pp_d[0]   = pre_p;
        end
        for (int n = 1; n <= K; n++) begin
            if (rdy[n]) begin
                v_d[n]    = v_q[n-1];
                ci_d[n]   = ci_q[n-1];
                praw_d[n] = praw_q[n-1];
                gg_d[n]   = cg[n];
                pp_d[n]   = cp[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            ci_q   <= '0;
            praw_q <= '0;
            gg_q   <= '0;
            pp_q   <= '0;
        end else begin
            v_q    <= v_d;
            ci_q   <= ci_d;
            praw_q <= praw_d;
            gg_q   <= gg_d;
            pp_q   <= pp_d;
        end
    end

    // group propagate is not needed once every prefix is resolved
    logic unused_pk;
    assign unused_pk = ^pp_q[K];

    assign in_ready  = rdy[0];
    assign out_valid = v_q[K];
    assign S = {gg_q[K][WIDTH-1], praw_q[K] ^ {gg_q[K][WIDTH-2:0], ci_q[K]}};

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Randomized and directed bench for prefix_adder_pipe (16-bit and 6-bit instances).
module tb_prefix_adder_pipe;
`ifdef ADDSUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, c_in, sub, out_valid, out_ready;
    logic [15:0] x, y;
    logic [16:0] s;
    logic        in_valid6, in_ready6, c_in6, out_valid6, out_ready6;
    logic [5:0]  x6, y6;
    logic [6:0]  s6;

    int checks = 0;
    int errors = 0;
    int n_seen = 0;
    logic [16:0] q16[$];
    logic [6:0]  q6[$];

    always #5 clk = ~clk;

    prefix_adder_pipe #(.WIDTH(16), .LVL_PER_STAGE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .X(x), .Y(y), .c_in(c_in),
`ifdef ADDSUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .S(s)
    );

    prefix_adder_pipe #(.WIDTH(6), .LVL_PER_STAGE(1)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
        .X(x6), .Y(y6), .c_in(c_in6),
`ifdef ADDSUB_EN
        .sub(1'b0),
`endif
        .out_valid(out_valid6), .out_ready(out_ready6), .S(s6)
    );

    function automatic logic [16:0] ref16(input logic [15:0] a, b, input logic ci, input logic sb);
        if (sb) return 17'(32'(a) + 32'h10000 - 32'(b));
        return 17'(32'(a) + 32'(b) + 32'(ci));
    endfunction

    function automatic logic [6:0] ref6(input logic [5:0] a, b, input logic ci);
        return 7'(int'(a) + int'(b) + int'(ci));
    endfunction

    task automatic step16(input logic iv, input logic [15:0] xv, yv, input logic ci, sb, ordy,
                          input int ir_exp);
        logic [16:0] e;
        @(negedge clk);
        in_valid = iv; x = xv; y = yv; c_in = ci; sub = sb; out_ready = ordy;
        #1;
        if (ir_exp >= 0) begin
            checks++;
            assert (in_ready === ir_exp[0]) else begin
                errors++; $error("FAIL in_ready16 got=%b expected=%b", in_ready, ir_exp[0]);
            end
        end
        if (out_valid && out_ready) begin
            n_seen++;
            checks++;
            assert (q16.size() > 0) else begin
                errors++; $error("FAIL spurious16 got=%h expected=none", s);
            end
            if (q16.size() > 0) begin
                e = q16.pop_front();
                checks++;
                assert (s === e) else begin
                    errors++; $error("FAIL sum16 got=%h expected=%h", s, e);
                end
            end
        end
        if (in_valid && in_ready) q16.push_back(ref16(x, y, c_in, sub));
        @(posedge clk);
    endtask

    task automatic step6(input logic iv, input logic [5:0] xv, yv, input logic ci);
        logic [6:0] e;
        @(negedge clk);
        in_valid6 = iv; x6 = xv; y6 = yv; c_in6 = ci; out_ready6 = 1'b1;
        #1;
        if (out_valid6) begin
            checks++;
            assert (q6.size() > 0) else begin
                errors++; $error("FAIL spurious6 got=%h expected=none", s6);
            end
            if (q6.size() > 0) begin
                e = q6.pop_front();
                checks++;
                assert (s6 === e) else begin
                    errors++; $error("FAIL sum6 got=%h expected=%h", s6, e);
                end
            end
        end
        if (in_valid6 && in_ready6) q6.push_back(ref6(x6, y6, c_in6));
        @(posedge clk);
    endtask

    // one beat into an empty pipe; checks accept-to-valid latency and the sum
    task automatic single16(input logic [15:0] xv, yv, input logic ci, sb,
                            input logic [16:0] exp_s, input string tag);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; x = xv; y = yv; c_in = ci; sub = sb; out_ready = 1'b1;
        #1;
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++; $error("FAIL accept_%s got=%b expected=1", tag, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        #1;
        checks++;
        assert (lat == 3) else begin
            errors++; $error("FAIL lat_%s got=%0d expected=3", tag, lat);
        end
        checks++;
        assert (s === exp_s) else begin
            errors++; $error("FAIL sum_%s got=%h expected=%h", tag, s, exp_s);
        end
        @(posedge clk);
    endtask

    initial begin
        int seen0;
        logic sb;
        rst_n = 1'b0;
        in_valid = 1'b0; x = '0; y = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid6 = 1'b0; x6 = '0; y6 = '0; c_in6 = 1'b0; out_ready6 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_ovalid got=%b expected=0", out_valid); end
        checks++;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL rst_iready got=%b expected=1", in_ready); end
        checks++;
        assert (s === 17'h0) else begin errors++; $error("FAIL rst_s got=%h expected=0", s); end
        checks++;
        assert (out_valid6 === 1'b0 && s6 === 7'h0) else begin
            errors++; $error("FAIL rst6 got=%b/%h expected=0/0", out_valid6, s6);
        end
        rst_n = 1'b1;

        single16(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, "basic");
        single16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, "allones");
        single16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000, "ripple");
        single16(16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000, "zero");
`ifdef ADDSUB_EN
        single16(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, "sub_borrow");
        single16(16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002, "sub_noborrow");
`endif

        // streaming: one result per cycle once the pipe is primed
        seen0 = n_seen;
        for (int i = 0; i < 100; i++) begin
            sb = HAS_SUB & 1'($urandom_range(0, 1));
            step16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), sb, 1'b1, 1);
        end
        checks++;
        assert (n_seen - seen0 == 97) else begin
            errors++; $error("FAIL stream_rate got=%0d expected=97", n_seen - seen0);
        end
        repeat (5) step16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, -1);
        checks++;
        assert (q16.size() == 0) else begin errors++; $error("FAIL stream_drain got=%0d expected=0", q16.size()); end

        // backpressure: fill, stall, then random bubbles on both sides
        repeat (5) step16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b0;
            #1;
            checks++;
            assert (out_valid === 1'b1 && s === q16[0]) else begin
                errors++; $error("FAIL stall_hold got=%b/%h expected=1/%h", out_valid, s, q16[0]);
            end
            checks++;
            assert (in_ready === 1'b0) else begin errors++; $error("FAIL stall_iready got=%b expected=0", in_ready); end
            @(posedge clk);
        end
        for (int i = 0; i < 80; i++) begin
            sb = HAS_SUB & 1'($urandom_range(0, 1));
            step16(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), sb,
                   ($urandom_range(0, 9) < 6), -1);
        end
        repeat (10) step16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, -1);
        checks++;
        assert (q16.size() == 0) else begin errors++; $error("FAIL bp_drain got=%0d expected=0", q16.size()); end

        // reset with three beats in flight
        repeat (3) step16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b1, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL midrst_ovalid got=%b expected=0", out_valid); end
        checks++;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL midrst_iready got=%b expected=1", in_ready); end
        q16.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen0 = n_seen;
        repeat (8) step16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1);
        checks++;
        assert (n_seen == seen0) else begin errors++; $error("FAIL stale got=%0d expected=0", n_seen - seen0); end

        // exhaustive 6-bit add sweep
        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 64; b++)
                for (int c = 0; c < 2; c++)
                    step6(1'b1, 6'(a), 6'(b), 1'(c));
        repeat (6) step6(1'b0, '0, '0, 1'b0);
        checks++;
        assert (q6.size() == 0) else begin errors++; $error("FAIL sweep6_drain got=%0d expected=0", q6.size()); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
